// File: rtl/core_pkg.sv
// Shared core definitions: instruction-memory loader state and sizing.
package core_pkg;

    typedef enum logic [1:0] {
        HDR,
        DATA,
        DONE
    } ld_state_t;

    localparam int HDR_BYTES   = 4;
    localparam int IMEM_ADDR_W = 14;

endpackage

// File: rtl/imem_loader_if.sv
// Fetch read port, UART byte stream and load status of the imem loader.
interface imem_loader_if
    import core_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              reload;
    logic [31:0]       imemraddr;
    logic [31:0]       imemrdata;
    logic              loaded;
    logic              overflow;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output rx_valid, rx_data, reload, imemraddr,
        input  imemrdata, loaded, overflow, words_loaded
    );

    modport slave (
        input  rx_valid, rx_data, reload, imemraddr,
        output imemrdata, loaded, overflow, words_loaded
    );

endinterface

// File: rtl/imem_bram.sv
// Instruction BRAM: one write port, one synchronous read-first read port.
module imem_bram
    import core_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills the instruction BRAM from a UART byte stream
// (LE word-count header, then LE words) and serves fetch reads.
module imem_loader
    import core_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic clk,
    input  logic rstn,
    imem_loader_if.slave bus
);

    ld_state_t         state_q;
    ld_state_t         state_d;
    logic [1:0]        byte_idx;
    logic [23:0]       byte_buf;
    logic [31:0]       hdr_cnt;
    logic [31:0]       rcv_cnt;
    logic [ADDR_W:0]   wl_q;
    logic              overflow_q;
    logic              rd_ok;
    logic [31:0]       rdata;
    logic [31:0]       word;
    logic              take;
    logic              word_done;
    logic              room;
    logic              last_word;
    logic              we;
    logic              loaded;
    logic              unused_addr;

    assign take      = bus.rx_valid && (state_q != DONE);
    assign word_done = take && (byte_idx == 2'(HDR_BYTES - 1));
    assign word      = {bus.rx_data, byte_buf};
    // wl_q doubles as the write pointer; its top bit means memory is full
    assign room      = !wl_q[ADDR_W];
    assign last_word = (rcv_cnt + 32'd1) == hdr_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HDR: begin
                if (word_done) begin
                    state_d = (word == 32'd0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (word_done && last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.reload) begin
                    state_d = HDR;
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        we     = 1'b0;
        loaded = 1'b0;
        unique case (state_q)
            DATA:    we     = word_done && room;
            DONE:    loaded = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_idx   <= '0;
            byte_buf   <= '0;
            hdr_cnt    <= '0;
            rcv_cnt    <= '0;
            wl_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            // bytes enter at the top so byte 0 ends up in bits [7:0]
            if (take) begin
                byte_idx <= byte_idx + 2'd1;
                byte_buf <= {bus.rx_data, byte_buf[23:8]};
            end
            if (state_q == HDR && word_done) begin
                hdr_cnt <= word;
                rcv_cnt <= '0;
                wl_q    <= '0;
            end
            if (state_q == DATA && word_done) begin
                rcv_cnt <= rcv_cnt + 32'd1;
                if (room) begin
                    wl_q <= wl_q + (ADDR_W + 1)'(1);
                end else begin
                    overflow_q <= 1'b1;
                end
            end
            if (state_q == DONE && bus.reload) begin
                byte_idx   <= '0;
                wl_q       <= '0;
                overflow_q <= 1'b0;
            end
        end
    end

    // masks the unreset BRAM output register until the first clock after reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ok <= 1'b0;
        end else begin
            rd_ok <= 1'b1;
        end
    end

    imem_bram #(
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk   (clk),
        .we    (we),
        .waddr (wl_q[ADDR_W-1:0]),
        .wdata (word),
        .raddr (bus.imemraddr[ADDR_W+1:2]),
        .rdata (rdata)
    );

    assign bus.imemrdata    = rd_ok ? rdata : 32'd0;
    assign bus.loaded       = loaded;
    assign bus.overflow     = overflow_q;
    assign bus.words_loaded = wl_q;
    assign unused_addr = ^{bus.imemraddr[31:ADDR_W+2], bus.imemraddr[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader with a stream-level model.
module tb_imem_loader;
    import core_pkg::*;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(AW)) bif ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif)
    );

    typedef struct {
        bit            chk_rd;
        logic [31:0]   rd;
        bit            ld;
        bit            ov;
        logic [AW:0]   wl;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_bad = 0;

    // model: the load is described only by how many stream bytes were taken
    logic [31:0] mmem   [DEPTH];
    bit          mknown [DEPTH];
    longint      m_bytes = 0;
    longint      m_cnt   = 0;
    logic [31:0] m_buf   = '0;

    bit          pin     = 1'b0;
    logic [31:0] pin_val = '0;
    logic [31:0] wq[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint m_words();
        return (m_bytes >= 4) ? (m_bytes / 4 - 1) : 0;
    endfunction

    function automatic bit m_done();
        return (m_bytes >= 4) && (m_words() >= m_cnt);
    endfunction

    task automatic add_byte(logic [7:0] d);
        longint k;
        m_buf[(m_bytes % 4) * 8 +: 8] = d;
        m_bytes++;
        if (m_bytes % 4 == 0) begin
            if (m_bytes == 4) begin
                m_cnt = longint'(m_buf);
            end else begin
                k = m_bytes / 4 - 2;
                if (k < DEPTH) begin
                    mmem[k]   = m_buf;
                    mknown[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic apply(bit v, logic [7:0] d, bit rel);
        exp_t e;
        int idx;
        logic [31:0] a;
        longint w;
        a = pin ? pin_val : $urandom;
        bif.rx_valid  = v;
        bif.rx_data   = d;
        bif.reload    = rel;
        bif.imemraddr = a;
        idx = int'(a[AW+1:2]);
        e.chk_rd = mknown[idx];
        e.rd     = mmem[idx];
        if (rel && m_done()) begin
            m_bytes = 0;
            m_cnt   = 0;
        end else if (v && !m_done()) begin
            add_byte(d);
        end
        w = m_words();
        e.ld = m_done();
        e.ov = w > DEPTH;
        e.wl = (AW + 1)'((w > DEPTH) ? DEPTH : w);
        q.push_back(e);
    endtask

    task automatic cyc(bit v, logic [7:0] d, bit rel);
        @(negedge clk);
        apply(v, d, rel);
    endtask

    task automatic idle(int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(logic [7:0] d);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) cyc(1'b0, 8'h00, !m_done() && ($urandom_range(0, 3) == 0));
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic send_word(logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    task automatic load(logic [31:0] hdr);
        send_word(hdr);
        foreach (wq[i]) send_word(wq[i]);
    endtask

    task automatic fill_wq(int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    task automatic reload_pulse();
        cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_imemrdata", bif.imemrdata, 32'd0);
        check("rst_loaded", {31'd0, bif.loaded}, 32'd0);
        check("rst_overflow", {31'd0, bif.overflow}, 32'd0);
        check("rst_words_loaded", {29'd0, bif.words_loaded}, 32'd0);
        #1;
        rstn = 1'b1;
        m_bytes = 0;
        m_cnt   = 0;
        apply(1'b0, 8'h00, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_rd) check("imemrdata", bif.imemrdata, e.rd);
                check("loaded", {31'd0, bif.loaded}, {31'd0, e.ld});
                check("overflow", {31'd0, bif.overflow}, {31'd0, e.ov});
                check("words_loaded", {29'd0, bif.words_loaded}, {29'd0, e.wl});
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        bif.rx_valid  = 1'b0;
        bif.rx_data   = 8'h00;
        bif.reload    = 1'b0;
        bif.imemraddr = 32'd0;
        for (int i = 0; i < DEPTH; i++) mknown[i] = 1'b0;

        do_reset();

        wq = '{32'h00100513, 32'h0000006F};
        load(32'd2);
        pin = 1'b1;
        pin_val = 32'd0;
        idle(2);
        pin_val = 32'd4;
        idle(2);
        pin = 1'b0;

        repeat (6) send(8'($urandom));
        idle(2);

        reload_pulse();
        send_word(32'd0);
        idle(3);

        reload_pulse();
        wq = '{32'hEFBEADDE};
        load(32'd1);
        pin = 1'b1;
        pin_val = 32'd0;
        idle(2);
        pin = 1'b0;

        reload_pulse();
        fill_wq(5);
        load(32'd5);
        idle(4);

        reload_pulse();
        pin = 1'b1;
        pin_val = 32'd8;
        fill_wq(3);
        load(32'd3);
        idle(3);
        pin = 1'b0;

        reload_pulse();
        fill_wq(3);
        send_word(32'd3);
        send_word(wq[0]);
        send_word(wq[1]);
        do_reset();
        fill_wq(1);
        load(32'd1);
        idle(3);

        for (int r = 0; r < 14; r++) begin
            reload_pulse();
            n = $urandom_range(0, 6);
            fill_wq(n);
            if ($urandom_range(0, 4) == 0 && n > 1) begin
                send_word(32'(n));
                send_word(wq[0]);
                send(8'($urandom));
                do_reset();
            end
            load(32'(n));
            repeat ($urandom_range(0, 3)) send(8'($urandom));
            idle($urandom_range(1, 4));
        end

        idle(3);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Responder side of the fetch-stage instruction-memory interface: serves `imemraddr` and returns `imemrdata` one cycle later.
- Owns the instruction BRAM and fills it at boot from a byte stream delivered by the UART receiver (valid/data).
- Stream format: a 4-byte little-endian word-count header, then the program words, each little-endian.
- Asserts `loaded` when the program is in memory, so core control can release fetch.

Parameters:
ADDR_W, 14, word-address width; memory depth = 2**ADDR_W 32-bit words.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
rx_data  in  8  received byte
reload  in  1  one-cycle pulse; from DONE, restart loading (new header expected)
imemraddr  in  32  fetch byte address; word index = imemraddr[ADDR_W+1:2]; bits [1:0] ignored
imemrdata  out  32  instruction word at the address presented in the previous cycle
loaded  out  1  high in DONE
overflow  out  1  sticky: header count exceeded depth
words_loaded  out  ADDR_W+1  number of words written since the last load start

Behaviour:
- Reset (rstn low, asynchronous) sets:
  - state = HDR, byte_idx = 0, hdr_cnt = 0, words_loaded = 0.
  - overflow = 0, loaded = 0, imemrdata = 0.
  - BRAM contents are not reset.
- Read port:
  - Synchronous, latency 1: imemrdata(t+1) = mem[imemraddr(t) word index].
  - Active in every state, including during loading.
  - Read and write to the same word in the same cycle returns the OLD data (read-first).
- Byte assembly:
  - byte_idx (2 bits) counts rx_valid strobes.
  - A byte lands in lane byte_idx: byte 0 -> bits[7:0], byte 3 -> bits[31:24].
  - The word is complete on the 4th strobe; byte_idx wraps 3 -> 0.
- State machine {HDR, DATA, DONE}:
  - HDR:
    - On the 4th header byte, latch hdr_cnt (32 bits).
    - If hdr_cnt == 0, go to DONE.
    - Otherwise go to DATA, with wr_ptr = 0.
  - DATA: on each completed word:
    - If wr_ptr < 2**ADDR_W: write the word to mem[wr_ptr]; increment wr_ptr and words_loaded.
    - Otherwise: discard the word and set overflow.
    - When the received word count equals hdr_cnt, go to DONE in the same cycle as the final write.
  - DONE:
    - loaded = 1; rx_valid is ignored.
    - reload -> HDR: clears byte_idx, words_loaded, overflow; loaded drops the next cycle.
  - reload in HDR or DATA is ignored.
- Write timing: the BRAM write occurs in the cycle the 4th byte strobe is sampled. The word is readable via the read port the following cycle (issue the address at t+1, data at t+2).
- words_loaded saturates at 2**ADDR_W, which is why the port is ADDR_W+1 bits wide.
- Reset mid-load: all loader state is cleared immediately. Partially written memory words remain; the load restarts from the header.
- No backpressure: rx_valid is at most 1 per cycle, and every strobe is consumed.

Decomposition:
- Shared package core_pkg gets:
  - the loader state enum {HDR, DATA, DONE};
  - the constant HDR_BYTES = 4;
  - the default ADDR_W.
- Sub-module imem_bram (ADDR_W):
  - one write port (we, waddr, wdata);
  - one synchronous read-first read port;
  - written so synthesis infers block RAM.
- imem_loader holds the FSM, byte assembler and counters, and instantiates imem_bram.

Test Plan:
- Header 02 00 00 00, then bytes 13 05 10 00, 6F 00 00 00 ->
  - loaded=1 the cycle after the last byte; words_loaded=2;
  - imemraddr=0 -> imemrdata=0x00100513 next cycle;
  - imemraddr=4 -> 0x0000006F.
- Header 00 00 00 00 -> DONE after the 4th byte; words_loaded=0; overflow=0.
- ADDR_W=2, header 05 00 00 00 with 5 words ->
  - mem[0..3] written, 5th word discarded;
  - overflow=1, words_loaded=4, loaded=1.
- Assert rstn=0 mid-DATA after 2 of 3 words ->
  - loaded=0, words_loaded=0, imemrdata=0 immediately;
  - a new 1-word load writes mem[0] and asserts loaded.
- In DONE: send extra bytes -> memory unchanged. Then pulse reload and send header 01 00 00 00 + DE AD BE EF -> mem[0]=0xEFBEADDE, loaded re-asserts.
- Read addr 8 continuously while word 2 is being written -> the read in the write cycle returns the old value; the next cycle returns the new word.
